// File: rtl/reg_file.sv
// MIPS register file: NREGS x WIDTH entries with $zero at entry 0, two
// combinational read ports, one synchronous write port, optional WB->ID bypass.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2
);

    localparam bit BYP_EN = (BYPASS != 32'sd0);

    logic [WIDTH-1:0] entry_s [NREGS];
    logic             wr_live_s;

    // A write is only real when not in reset and not aimed at $zero.
    assign wr_live_s = wen && !rst && (waddr != {AW{1'b0}});

    // Entry 0 has no storage; it is the constant-zero register.
    assign entry_s[0] = {WIDTH{1'b0}};

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_entry
            logic             wen_s;
            logic [WIDTH-1:0] q_r;

            assign wen_s = wen && (waddr == AW'(i));

            // Enabled register for entry i; reset wins over a concurrent write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_r <= {WIDTH{1'b0}};
                end else if (wen_s) begin
                    q_r <= wdata;
                end else begin
                    q_r <= q_r;
                end
            end

            assign entry_s[i] = q_r;
        end
    endgenerate

    // Read port 1: $zero first, then same-cycle bypass, then stored value.
    always_comb begin
        rdata1 = {WIDTH{1'b0}};
        if (raddr1 == {AW{1'b0}}) begin
            rdata1 = {WIDTH{1'b0}};
        end else if (BYP_EN && wr_live_s && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = entry_s[raddr1];
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        rdata2 = {WIDTH{1'b0}};
        if (raddr2 == {AW{1'b0}}) begin
            rdata2 = {WIDTH{1'b0}};
        end else if (BYP_EN && wr_live_s && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = entry_s[raddr2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array model, run on a bypassing and a non-bypassing instance.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    logic [31:0] model [32];
    int          ncomp;
    int          nfail;

    reg_file #(.WIDTH(32), .NREGS(32), .AW(5), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b)
    );

    reg_file #(.WIDTH(32), .NREGS(32), .AW(5), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_n), .raddr2(raddr2), .rdata2(rd2_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read value from the architectural rules.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && wen && !rst && waddr != 5'd0 && a == waddr) return wdata;
        return model[a];
    endfunction

    // Apply the current inputs to the model, then let the DUT take the edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wen && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        raddr1 = 5'd0; raddr2 = 5'd0; rst = 1'b0; wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        #1;
        ncomp++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
            nfail++;
            $display("FAIL zero_before_reset: got %h %h %h %h want 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
        wen = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; wen = 1'b1; wdata = 32'hFFFFFFFF;
        for (int a = 1; a < 32; a++) begin
            waddr = 5'(a);
            tick();
        end
        wen = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(a);
            @(negedge clk);
            ncomp++;
            if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
                nfail++;
                $display("FAIL reset_clear a=%0d: got %h %h %h %h want 0", a, rd1_b, rd2_b, rd1_n, rd2_n);
            end
        end
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        wen = 1'b1; waddr = 5'd5; wdata = 32'hABCDABCD;
        tick();
        wen = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'hABCDABCD || rd1_n !== 32'hABCDABCD) begin
            nfail++;
            $display("FAIL write_read r5: got %h %h want abcdabcd", rd1_b, rd1_n);
        end
        ncomp++;
        if (rd2_b !== 32'h0 || rd2_n !== 32'h0) begin
            nfail++;
            $display("FAIL write_read r6: got %h %h want 0", rd2_b, rd2_n);
        end
    endtask

    task automatic test_hold();
        @(posedge clk); #1;
        wen = 1'b0; waddr = 5'd5; wdata = 32'hBABAADAD;
        repeat (3) tick();
        raddr1 = 5'd5;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'hABCDABCD || rd1_n !== 32'hABCDABCD) begin
            nfail++;
            $display("FAIL hold r5: got %h %h want abcdabcd", rd1_b, rd1_n);
        end
    endtask

    task automatic test_zero_reg();
        @(posedge clk); #1;
        wen = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; raddr2 = 5'd0;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
            nfail++;
            $display("FAIL zero_reg_before: got %h %h %h %h want 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
        tick();
        wen = 1'b0;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
            nfail++;
            $display("FAIL zero_reg_after: got %h %h %h %h want 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_bypass();
        @(posedge clk); #1;
        wen = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        tick();
        wdata = 32'hAD12BA34; raddr1 = 5'd7; raddr2 = 5'd7;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'hAD12BA34 || rd2_b !== 32'hAD12BA34) begin
            nfail++;
            $display("FAIL bypass_on: got %h %h want ad12ba34", rd1_b, rd2_b);
        end
        ncomp++;
        if (rd1_n !== 32'h11111111 || rd2_n !== 32'h11111111) begin
            nfail++;
            $display("FAIL bypass_off_before: got %h %h want 11111111", rd1_n, rd2_n);
        end
        tick();
        wen = 1'b0;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'hAD12BA34 || rd2_b !== 32'hAD12BA34 || rd1_n !== 32'hAD12BA34 || rd2_n !== 32'hAD12BA34) begin
            nfail++;
            $display("FAIL bypass_after: got %h %h %h %h want ad12ba34", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_rst_vs_wen();
        @(posedge clk); #1;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h55555555;
        tick();
        rst = 1'b1; wdata = 32'hDEADBEEF; raddr1 = 5'd9; raddr2 = 5'd9;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'h55555555 || rd2_n !== 32'h55555555) begin
            nfail++;
            $display("FAIL rst_blocks_bypass: got %h %h want 55555555", rd1_b, rd2_n);
        end
        tick();
        rst = 1'b0; wen = 1'b0;
        @(negedge clk);
        ncomp++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
            nfail++;
            $display("FAIL rst_vs_wen r9: got %h %h %h %h want 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        @(posedge clk); #1;
        raddr1 = 5'd3; raddr2 = 5'd3; wen = 1'b1; waddr = 5'd3;
        for (int i = 0; i < 8; i++) begin
            prev  = model[3];
            wdata = $urandom;
            @(negedge clk);
            ncomp++;
            if (rd1_b !== wdata || rd1_n !== prev) begin
                nfail++;
                $display("FAIL back_to_back i=%0d: got %h %h want %h %h", i, rd1_b, rd1_n, wdata, prev);
            end
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic test_random();
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(39, 0) == 0);
            wen    = ($urandom_range(1, 0) == 1);
            waddr  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
            wdata  = $urandom;
            raddr1 = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom_range(31, 0));
            raddr2 = ($urandom_range(3, 0) == 0) ? raddr1 : 5'($urandom_range(31, 0));
            @(negedge clk);
            ncomp++;
            if (rd1_b !== exp_rd(raddr1, 1'b1) || rd2_b !== exp_rd(raddr2, 1'b1)) begin
                nfail++;
                $display("FAIL random_byp n=%0d a=%0d/%0d: got %h %h want %h %h", n, raddr1, raddr2,
                         rd1_b, rd2_b, exp_rd(raddr1, 1'b1), exp_rd(raddr2, 1'b1));
            end
            ncomp++;
            if (rd1_n !== exp_rd(raddr1, 1'b0) || rd2_n !== exp_rd(raddr2, 1'b0)) begin
                nfail++;
                $display("FAIL random_nob n=%0d a=%0d/%0d: got %h %h want %h %h", n, raddr1, raddr2,
                         rd1_n, rd2_n, exp_rd(raddr1, 1'b0), exp_rd(raddr2, 1'b0));
            end
            tick();
        end
        rst = 1'b0; wen = 1'b0;
    endtask

    initial begin
        ncomp = 0;
        nfail = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        test_reset();
        test_write_read();
        test_hold();
        test_zero_reg();
        test_bypass();
        test_rst_vs_wen();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
